// File: rtl/galaxian_input_cond.sv
// Switch conditioner: invert, synchronise and debounce every channel, then shape
// coin channels into fixed-length pulses and fire channels into an autofire square wave.
module galaxian_input_cond #(
  parameter int              N_SW          = 9,
  parameter int              DEB_CYCLES    = 36864,
  parameter logic [N_SW-1:0] INV_MASK      = 9'h000,
  parameter logic [N_SW-1:0] COIN_MASK     = 9'h140,
  parameter int              COIN_PULSE    = 3686400,
  parameter logic [N_SW-1:0] FIRE_MASK     = 9'h010,
  parameter int              AUTOFIRE_HALF = 1843200
) (
  input  logic            CLK_36M,
  input  logic            I_RESET_SWn,
  input  logic [N_SW-1:0] I_RAW,
  input  logic            I_AUTOFIRE_EN,
  output logic [N_SW-1:0] O_SW,
  output logic [N_SW-1:0] O_RISE
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int CW = $clog2(COIN_PULSE + 1);
  localparam int FW = $clog2(AUTOFIRE_HALF + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] COIN_LAST = CW'(COIN_PULSE);
  localparam logic [FW-1:0] FIRE_LAST = FW'(AUTOFIRE_HALF);

  logic [N_SW-1:0] s1_q;
  logic [N_SW-1:0] s2_q;
  logic [N_SW-1:0] deb_q;
  logic [N_SW-1:0] deb_d;
  logic [N_SW-1:0] rise_q;

  always_ff @(posedge CLK_36M or negedge I_RESET_SWn) begin
    if (!I_RESET_SWn) begin
      s1_q   <= '0;
      s2_q   <= '0;
      deb_q  <= '0;
      rise_q <= '0;
    end else begin
      s1_q   <= I_RAW ^ INV_MASK;
      s2_q   <= s1_q;
      deb_q  <= deb_d;
      rise_q <= deb_d & ~deb_q;
    end
  end

  assign O_RISE = rise_q;

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic          lvl_d;

    // The counter holds the number of earlier consecutive disagreeing samples, so the
    // level flips on the DEB_CYCLES-th disagreement and the counter never wraps.
    always_comb begin
      cnt_d = '0;
      lvl_d = deb_q[i];
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q == DEB_LAST) begin
          lvl_d = s2_q[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge CLK_36M or negedge I_RESET_SWn) begin
      if (!I_RESET_SWn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign deb_d[i] = lvl_d;

    if (COIN_MASK[i]) begin : g_coin
      typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT_REL} coin_state_e;
      coin_state_e   state_q;
      logic [CW-1:0] pcnt_q;
      logic          out_q;

      // Transitions look at the level being loaded this edge, so a rise coinciding
      // with pulse expiry lands in WAIT_REL instead of retriggering.
      always_ff @(posedge CLK_36M or negedge I_RESET_SWn) begin
        if (!I_RESET_SWn) begin
          state_q <= ST_IDLE;
          pcnt_q  <= '0;
          out_q   <= 1'b0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (lvl_d && !deb_q[i]) begin
                state_q <= ST_PULSE;
                pcnt_q  <= CW'(1);
                out_q   <= 1'b1;
              end
            end
            ST_PULSE: begin
              if (pcnt_q == COIN_LAST) begin
                pcnt_q  <= '0;
                out_q   <= 1'b0;
                state_q <= lvl_d ? ST_WAIT_REL : ST_IDLE;
              end else begin
                pcnt_q <= pcnt_q + 1'b1;
              end
            end
            ST_WAIT_REL: begin
              if (!lvl_d) begin
                state_q <= ST_IDLE;
              end
            end
            default: begin
              state_q <= ST_IDLE;
              pcnt_q  <= '0;
              out_q   <= 1'b0;
            end
          endcase
        end
      end

      assign O_SW[i] = out_q;
    end else if (FIRE_MASK[i]) begin : g_fire
      logic [FW-1:0] ph_q;
      logic          out_q;

      // ph_q == 0 means autofire is idle; any (re)start begins with a high phase.
      always_ff @(posedge CLK_36M or negedge I_RESET_SWn) begin
        if (!I_RESET_SWn) begin
          ph_q  <= '0;
          out_q <= 1'b0;
        end else if (!I_AUTOFIRE_EN || !lvl_d) begin
          ph_q  <= '0;
          out_q <= lvl_d;
        end else if (ph_q == '0) begin
          ph_q  <= FW'(1);
          out_q <= 1'b1;
        end else if (ph_q == FIRE_LAST) begin
          ph_q  <= FW'(1);
          out_q <= ~out_q;
        end else begin
          ph_q <= ph_q + 1'b1;
        end
      end

      assign O_SW[i] = out_q;
    end else begin : g_plain
      assign O_SW[i] = deb_q[i];
    end
  end

endmodule
